// File: rtl/clk_div_sched.sv
// Programmable clock divider: produces clk_out at clk/N with glitch-free start, stop
// and ratio changes that only take effect on output-period boundaries.
module clk_div_sched #(
  parameter int W        = 8,
  parameter int DIV_INIT = 2
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         cfg_valid,
  input  logic [W-1:0] cfg_div,
  output logic         cfg_ready,
  output logic         cfg_err,
  output logic         clk_out,
  output logic         tick,
  output logic         busy,
  output logic [W-1:0] cur_div
);

  typedef enum logic {IDLE, RUN} state_t;

  state_t       state;
  logic [W-1:0] cnt;
  logic [W-1:0] pend;
  logic         pend_full;
  logic         accept;
  logic         wrap;
  logic [W:0]   cnt_nxt;
  logic [W:0]   high_len;

  // Ratios below 2 cannot produce a clock with both phases, so clamp them to 2.
  function automatic logic [W-1:0] coerce(input logic [W-1:0] d);
    return (d < W'(2)) ? W'(2) : d;
  endfunction

  always_comb begin
    accept   = cfg_valid && cfg_ready;
    wrap     = (cnt == cur_div - W'(1));
    cnt_nxt  = {1'b0, cnt} + (W+1)'(1);
    high_len = {1'b0, cur_div} - {2'b00, cur_div[W-1:1]};
  end

  always_ff @(posedge clk) begin
    if (accept && state == RUN)
      pend <= coerce(cfg_div);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      cur_div   <= W'(DIV_INIT);
      pend_full <= 1'b0;
      cfg_ready <= 1'b1;
      cfg_err   <= 1'b0;
      clk_out   <= 1'b0;
      tick      <= 1'b0;
      busy      <= 1'b0;
    end else begin
      cfg_err <= accept && (cfg_div < W'(2));
      tick    <= 1'b0;
      case (state)
        IDLE: begin
          // A ratio parked by a config taken on the stopping wrap lands here.
          if (pend_full) begin
            cur_div   <= pend;
            pend_full <= 1'b0;
            cfg_ready <= 1'b1;
          end else if (accept) begin
            cur_div <= coerce(cfg_div);
          end
          if (en) begin
            state   <= RUN;
            cnt     <= '0;
            clk_out <= 1'b1;
            tick    <= 1'b1;
            busy    <= 1'b1;
          end
        end
        RUN: begin
          if (wrap) begin
            if (pend_full) begin
              cur_div   <= pend;
              pend_full <= 1'b0;
              cfg_ready <= 1'b1;
            end
            cnt <= '0;
            if (en) begin
              clk_out <= 1'b1;
              tick    <= 1'b1;
            end else begin
              state   <= IDLE;
              clk_out <= 1'b0;
              busy    <= 1'b0;
            end
          end else begin
            cnt     <= cnt + W'(1);
            clk_out <= (cnt_nxt < high_len);
          end
          // cfg_ready is low whenever the slot is full, so this never collides with the apply above.
          if (accept) begin
            pend_full <= 1'b1;
            cfg_ready <= 1'b0;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_clk_div_sched.sv
// Bench for clk_div_sched: directed scenarios plus random traffic, all checked against
// a period-level reference model (running flag, position in period, ratio, pending queue).
module tb_clk_div_sched;

  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         en;
  logic         cfg_valid;
  logic [W-1:0] cfg_div;
  logic         cfg_ready;
  logic         cfg_err;
  logic         clk_out;
  logic         tick;
  logic         busy;
  logic [W-1:0] cur_div;

  int errors = 0;
  int checks = 0;

  // Reference model state
  int m_run, m_pos, m_n, m_err;
  int pendq[$];

  clk_div_sched #(.W(W), .DIV_INIT(2)) dut (
    .clk(clk), .rst(rst), .en(en), .cfg_valid(cfg_valid), .cfg_div(cfg_div),
    .cfg_ready(cfg_ready), .cfg_err(cfg_err), .clk_out(clk_out), .tick(tick),
    .busy(busy), .cur_div(cur_div)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    m_run = 0; m_pos = 0; m_n = 2; m_err = 0;
    pendq.delete();
  endtask

  task automatic check_all(input string tag);
    chk({tag, ".clk_out"}, clk_out, (m_run != 0 && m_pos < m_n - m_n / 2));
    chk({tag, ".tick"}, tick, (m_run != 0 && m_pos == 0));
    chk({tag, ".busy"}, busy, (m_run != 0));
    chk({tag, ".cfg_ready"}, cfg_ready, (pendq.size() == 0));
    chk({tag, ".cfg_err"}, cfg_err, m_err);
    chk({tag, ".cur_div"}, cur_div, m_n);
  endtask

  // One clock cycle: drive inputs, advance the model by the specified rules, check outputs.
  task automatic step(input logic e, input logic v, input logic [W-1:0] d, input string tag);
    bit acc;
    int cd;
    en = e; cfg_valid = v; cfg_div = d;
    @(posedge clk);
    acc   = v && (pendq.size() == 0);
    cd    = (d < 2) ? 2 : int'(d);
    m_err = (acc && d < 2) ? 1 : 0;
    if (m_run == 0) begin
      if (pendq.size() != 0) m_n = pendq.pop_front();
      else if (acc) m_n = cd;
      if (e) begin m_run = 1; m_pos = 0; end
    end else begin
      if (m_pos == m_n - 1) begin
        if (pendq.size() != 0) m_n = pendq.pop_front();
        m_pos = 0;
        if (!e) m_run = 0;
      end else begin
        m_pos++;
      end
      if (acc) pendq.push_back(cd);
    end
    #1;
    check_all(tag);
  endtask

  task automatic steps(input int n, input logic e, input string tag);
    for (int i = 0; i < n; i++) step(e, 1'b0, '0, tag);
  endtask

  // Run with en held at e until the model reaches period position p (bounded).
  task automatic run_to_pos(input int p, input logic e, input string tag);
    int k;
    k = 0;
    while (!(m_run != 0 && m_pos == p) && k < 64) begin
      step(e, 1'b0, '0, tag);
      k++;
    end
    if (k >= 64) chk({tag, ".bound"}, 0, 1);
  endtask

  task automatic go_idle(input string tag);
    int k;
    k = 0;
    while ((m_run != 0 || pendq.size() != 0) && k < 300) begin
      step(1'b0, 1'b0, '0, tag);
      k++;
    end
    if (k >= 300) chk({tag, ".idle_bound"}, 0, 1);
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; cfg_valid = 1'b0; cfg_div = '0;
    model_reset();
    #1;
    check_all("reset");
    @(negedge clk); @(negedge clk);
    rst = 1'b0;
    #1;
    check_all("post_reset");

    // Default divide-by-2
    steps(10, 1'b1, "div2");
    go_idle("div2_stop");

    // Ratio 5 loaded in IDLE
    step(1'b0, 1'b1, 8'd5, "idle_cfg5");
    steps(16, 1'b1, "div5");
    go_idle("div5_stop");

    // Ratio 4, then 7 offered at cnt=1
    step(1'b0, 1'b1, 8'd4, "idle_cfg4");
    steps(6, 1'b1, "div4");
    run_to_pos(1, 1'b1, "div4_seek");
    step(1'b1, 1'b1, 8'd7, "cfg7_offer");
    steps(24, 1'b1, "div7");

    // Ratio 0 in RUN -> coerced to 2
    run_to_pos(2, 1'b1, "cfg0_seek");
    step(1'b1, 1'b1, 8'd0, "cfg0_offer");
    steps(14, 1'b1, "coerced2");
    go_idle("coerced_stop");

    // Ratio 6: en dropped in high phase, period completes then stops
    step(1'b0, 1'b1, 8'd6, "idle_cfg6");
    steps(7, 1'b1, "div6");
    run_to_pos(1, 1'b1, "div6_seek");
    steps(9, 1'b0, "div6_stop");
    // En dropped then re-raised before the wrap: no gap
    steps(7, 1'b1, "div6_restart");
    run_to_pos(1, 1'b1, "div6_seek2");
    run_to_pos(4, 1'b0, "div6_drop");
    steps(12, 1'b1, "div6_cancel");
    go_idle("div6_end");

    // Ratio 5, asynchronous reset in mid-high phase
    step(1'b0, 1'b1, 8'd5, "idle_cfg5b");
    steps(6, 1'b1, "div5b");
    run_to_pos(1, 1'b1, "div5b_seek");
    #3;
    rst = 1'b1;
    model_reset();
    #1;
    check_all("async_rst");
    @(negedge clk);
    rst = 1'b0;
    steps(8, 1'b1, "after_rst");

    // Random traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(0, 11) != 0), ($urandom_range(0, 3) == 0),
           W'($urandom_range(0, 9)), "random");
    end
    go_idle("random_end");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/clk_div_sched.md
Name: clk_div_sched

Overview:
- Programmable clock-divider controller: generates a divided clock `clk_out` from `clk` with a runtime-selectable ratio N.
- Sequences start, stop and ratio changes so they only take effect at output-period boundaries, giving no runt pulses.
- Sits between configuration logic (valid/ready config port) and downstream logic that consumes `clk_out` or the single-cycle `tick`.
- With the default ratio and `en` held high it behaves as a plain divide-by-2.

Parameters:
- W, 8, width of the divide-ratio field and internal period counter.
- DIV_INIT, 2, reset value of the active ratio; must be in 2..2^W-1.

Ports:
- clk  in  1  system clock; all state updates on its rising edge.
- rst  in  1  asynchronous, active-high reset.
- en  in  1  run request; sampled in IDLE and at each period wrap only.
- cfg_valid  in  1  new ratio offered.
- cfg_div  in  W  requested ratio N.
- cfg_ready  out  1  config accepted when cfg_valid && cfg_ready at a clk edge.
- cfg_err  out  1  one-cycle pulse: accepted cfg_div < 2, coerced to 2.
- clk_out  out  1  divided clock, registered.
- tick  out  1  one-cycle pulse in the cycle clk_out is high after a rising transition.
- busy  out  1  high while in RUN.
- cur_div  out  W  ratio currently governing clk_out.

Behaviour:
- One clock; reset is asynchronous and active-high (ports clk, rst).
- Reset values, applied immediately without a clock edge:
  - clk_out=0, tick=0, busy=0, cfg_ready=1, cfg_err=0.
  - cur_div=DIV_INIT, pending slot empty, cnt=0, state=IDLE.
- Per-period shape for ratio N: period of N clk cycles; high phase H = N - floor(N/2) cycles, low phase floor(N/2) cycles.
- Internal counter cnt runs 0..N-1; clk_out is high while cnt < H.
- IDLE state:
  - clk_out=0, busy=0.
  - An accepted config writes cur_div directly (coerced if needed); cfg_ready stays 1.
  - en=1 at an edge: go to RUN, cnt<=0, clk_out<=1, tick<=1; first rising edge of clk_out is 1 cycle after en is sampled.
  - If a config is accepted on that same edge, the new ratio governs the first period.
- RUN state, non-wrap edge (cnt != cur_div-1): cnt<=cnt+1, clk_out<=(cnt+1 < H), tick<=0.
- RUN state, wrap edge (cnt == cur_div-1):
  - If the pending slot is full: cur_div<=pending, slot cleared, cfg_ready<=1.
  - en=1: cnt<=0, clk_out<=1, tick<=1.
  - en=0: go to IDLE, clk_out<=0, tick<=0, busy<=0.
  - Deasserting en mid-period never truncates the period; re-asserting en before the wrap cancels the stop.
- RUN config handshake:
  - An accepted config loads the pending slot; cfg_ready<=0 until the wrap that applies it.
  - A config accepted on a wrap edge is NOT applied at that wrap; it is applied at the next wrap.
  - Only one pending slot exists; a second offer waits, with cfg_valid held by the master.
- Coercion: accepted cfg_div of 0 or 1 is stored as 2; cfg_err=1 for the cycle after acceptance. Applies in either state.
- tick is high exactly once per period, coincident with the first high cycle of clk_out.
- Period boundaries are the only points where cur_div, clk_out phase or busy change (reset excepted).

Test Plan:
- Reset, en=1, no cfg -> clk_out 1,0,1,0… starting 1 cycle after en; tick every 2 cycles; cur_div=2; busy=1.
- In IDLE, cfg_div=5 accepted, then en=1 -> clk_out high 3 cycles, low 2, period 5; tick once per 5 cycles; cfg_ready stays 1.
- RUN at N=4, cfg_div=7 offered at cnt=1:
  - cfg_ready drops next cycle.
  - The current period completes at 4 cycles.
  - Following periods are high 4, low 3.
  - cfg_ready returns to 1 at that wrap; cur_div=7.
- cfg_div=0 accepted in RUN -> cfg_err one-cycle pulse; after next wrap cur_div=2 and clk_out toggles each cycle.
- N=6, en dropped at cnt=1 (high phase) -> period completes (3 high, 3 low), then clk_out=0, busy=0, no further tick. Second case: en re-raised at cnt=4 -> no gap in the output.
- RUN at N=5, rst asserted mid-high phase between clk edges -> clk_out, tick, busy fall to 0 immediately; cur_div=DIV_INIT; cfg_ready=1; after release with en=1, restarts 1 cycle later.
